// File: rtl/demux_stream_1ton_if.sv
// Stream bus for demux_stream_1ton: one producer port plus CHANNELS consumer ports.
// Port B exists only when DEMUX_STREAM_BROADCAST_EN is defined.
interface demux_stream_1ton_if #(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned CNT_W    = 8
);
  logic [WIDTH-1:0]          I;
  logic [SEL_W-1:0]          S;
  logic                      E;
  logic                      I_RDY;
  logic [CHANNELS*WIDTH-1:0] O;
  logic [CHANNELS-1:0]       O_VLD;
  logic [CHANNELS-1:0]       O_RDY;
  logic                      ERR;
  logic [CNT_W-1:0]          DROP_CNT;
`ifdef DEMUX_STREAM_BROADCAST_EN
  logic                      B;

  modport master (
    output I, S, E, B, O_RDY,
    input  I_RDY, O, O_VLD, ERR, DROP_CNT
  );

  modport slave (
    input  I, S, E, B, O_RDY,
    output I_RDY, O, O_VLD, ERR, DROP_CNT
  );
`else
  modport master (
    output I, S, E, O_RDY,
    input  I_RDY, O, O_VLD, ERR, DROP_CNT
  );

  modport slave (
    input  I, S, E, O_RDY,
    output I_RDY, O, O_VLD, ERR, DROP_CNT
  );
`endif
endinterface

// File: rtl/demux_stream_1ton.sv
// Registered 1-to-CHANNELS stream demux with per-channel valid/ready slots and a
// saturating drop counter. Define DEMUX_STREAM_BROADCAST_EN to add broadcast port B.
module demux_stream_1ton #(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned CNT_W    = 8
) (
  input logic               CLK,
  input logic               RST_N,
  demux_stream_1ton_if.slave bus
);

  logic [CHANNELS-1:0]       sel_hit;
  logic [CHANNELS-1:0]       slot_free;
  logic [CHANNELS-1:0]       load;
  logic                      sel_in_range;
  logic                      bcast;
  logic                      i_rdy;
  logic                      accept;
  logic                      drop;

  logic [CHANNELS*WIDTH-1:0] o_d, o_q;
  logic [CHANNELS-1:0]       o_vld_d, o_vld_q;
  logic                      err_d, err_q;
  logic [CNT_W-1:0]          drop_cnt_d, drop_cnt_q;

  // Select decode is a one-hot compare rather than an index, so out-of-range
  // selects simply hit no channel.
  always_comb begin
    sel_hit = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      sel_hit[k] = (32'(bus.S) == k);
    end
    sel_in_range = |sel_hit;
    slot_free    = ~o_vld_q | bus.O_RDY;
`ifdef DEMUX_STREAM_BROADCAST_EN
    bcast = bus.B;
`else
    bcast = 1'b0;
`endif
  end

  always_comb begin
    if (bcast) begin
      i_rdy = &slot_free;
    end else if (sel_in_range) begin
      i_rdy = |(sel_hit & slot_free);
    end else begin
      i_rdy = 1'b1;
    end
    accept = bus.E & i_rdy;
    load   = '0;
    if (accept) begin
      load = bcast ? '1 : sel_hit;
    end
    drop = accept & ~bcast & ~sel_in_range;
  end

  always_comb begin
    o_d     = o_q;
    o_vld_d = o_vld_q;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (load[k]) begin
        o_d[k*WIDTH +: WIDTH] = bus.I;
        o_vld_d[k]            = 1'b1;
      end else if (o_vld_q[k] && bus.O_RDY[k]) begin
        o_vld_d[k] = 1'b0;
      end
    end
  end

  always_comb begin
    err_d      = drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      o_q        <= '0;
      o_vld_q    <= '0;
      err_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      o_q        <= o_d;
      o_vld_q    <= o_vld_d;
      err_q      <= err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.I_RDY    = i_rdy;
  assign bus.O        = o_q;
  assign bus.O_VLD    = o_vld_q;
  assign bus.ERR      = err_q;
  assign bus.DROP_CNT = drop_cnt_q;

endmodule

// File: tb/tb_demux_stream_1ton.sv
// Bench for demux_stream_1ton: an 8-channel instance checked against a slot model,
// plus a 6-channel, 2-bit-counter instance for the drop path.
module tb_demux_stream_1ton;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  demux_stream_1ton_if #(.WIDTH(3), .CHANNELS(8), .SEL_W(3), .CNT_W(8)) bus0 ();
  demux_stream_1ton_if #(.WIDTH(3), .CHANNELS(6), .SEL_W(3), .CNT_W(2)) bus1 ();

  demux_stream_1ton #(.WIDTH(3), .CHANNELS(8), .SEL_W(3), .CNT_W(8)) dut0 (
    .CLK(clk), .RST_N(rst_n), .bus(bus0)
  );
  demux_stream_1ton #(.WIDTH(3), .CHANNELS(6), .SEL_W(3), .CNT_W(2)) dut1 (
    .CLK(clk), .RST_N(rst_n), .bus(bus1)
  );

  int unsigned total  = 0;
  int unsigned passed = 0;

  // Model of the 8-channel instance: what each consumer slot holds and whether it is full.
  logic [2:0] md [8];
  logic [7:0] mv;

  function automatic logic [23:0] m_o();
    logic [23:0] v;
    for (int k = 0; k < 8; k++) v[k*3 +: 3] = md[k];
    return v;
  endfunction

  function automatic logic m_rdy(input logic [2:0] s, input logic [7:0] ordy, input logic b);
    if (b) begin
      for (int k = 0; k < 8; k++) if (mv[k] && !ordy[k]) return 1'b0;
      return 1'b1;
    end
    return !mv[s] || ordy[s];
  endfunction

  task automatic m_reset();
    mv = '0;
    for (int k = 0; k < 8; k++) md[k] = '0;
  endtask

  // Update the model with the inputs present at the coming edge, then step past it.
  task automatic tick0();
    logic b;
    logic acc;
`ifdef DEMUX_STREAM_BROADCAST_EN
    b = bus0.B;
`else
    b = 1'b0;
`endif
    acc = bus0.E && m_rdy(bus0.S, bus0.O_RDY, b);
    for (int k = 0; k < 8; k++) begin
      if (acc && (b || int'(bus0.S) == k)) begin
        md[k] = bus0.I;
        mv[k] = 1'b1;
      end else if (mv[k] && bus0.O_RDY[k]) begin
        mv[k] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic e, input logic [2:0] s, input logic [2:0] i, input logic [7:0] ordy);
    bus0.E = e; bus0.S = s; bus0.I = i; bus0.O_RDY = ordy;
`ifdef DEMUX_STREAM_BROADCAST_EN
    bus0.B = 1'b0;
`endif
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive0(1'b0, 3'd0, 3'd0, 8'hFF);
    bus1.E = 1'b0; bus1.S = '0; bus1.I = '0; bus1.O_RDY = '1;
    m_reset();
    #1;
    total++; if (bus0.O !== 24'h0) $display("FAIL reset_o got %h exp 0", bus0.O); else passed++;
    total++; if (bus0.O_VLD !== 8'h0) $display("FAIL reset_vld got %h exp 0", bus0.O_VLD); else passed++;
    total++; if (bus0.ERR !== 1'b0 || bus0.DROP_CNT !== 8'h0)
      $display("FAIL reset_err_cnt got %b/%h exp 0/0", bus0.ERR, bus0.DROP_CNT); else passed++;
    total++; if (bus1.DROP_CNT !== 2'd0 || bus1.O_VLD !== 6'h0)
      $display("FAIL reset_dut1 got %h/%h exp 0/0", bus1.DROP_CNT, bus1.O_VLD); else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_route();
    for (int k = 0; k < 8; k++) begin
      drive0(1'b1, 3'(k), 3'(k), 8'hFF);
      total++; if (bus0.I_RDY !== 1'b1) $display("FAIL route_rdy ch%0d got %b exp 1", k, bus0.I_RDY); else passed++;
      tick0();
      total++; if (bus0.O_VLD !== (8'h1 << k)) $display("FAIL route_vld ch%0d got %h exp %h", k, bus0.O_VLD, 8'h1 << k); else passed++;
      total++; if (bus0.O[k*3 +: 3] !== 3'(k)) $display("FAIL route_data ch%0d got %0d exp %0d", k, bus0.O[k*3 +: 3], k); else passed++;
    end
    drive0(1'b0, 3'd0, 3'd0, 8'hFF);
    tick0();
    total++; if (bus0.O_VLD !== 8'h0) $display("FAIL route_drain got %h exp 0", bus0.O_VLD); else passed++;
    total++; if (bus0.O !== m_o()) $display("FAIL route_retain got %h exp %h", bus0.O, m_o()); else passed++;
  endtask

  task automatic test_backpressure();
    drive0(1'b1, 3'd2, 3'd5, 8'hFB);
    tick0();
    total++; if (bus0.O_VLD[2] !== 1'b1 || bus0.O[8:6] !== 3'd5)
      $display("FAIL bp_first got %b/%0d exp 1/5", bus0.O_VLD[2], bus0.O[8:6]); else passed++;
    drive0(1'b1, 3'd2, 3'd6, 8'hFB);
    total++; if (bus0.I_RDY !== 1'b0) $display("FAIL bp_stall_rdy got %b exp 0", bus0.I_RDY); else passed++;
    tick0();
    total++; if (bus0.O_VLD[2] !== 1'b1 || bus0.O[8:6] !== 3'd5)
      $display("FAIL bp_hold got %b/%0d exp 1/5", bus0.O_VLD[2], bus0.O[8:6]); else passed++;
    drive0(1'b1, 3'd2, 3'd6, 8'hFF);
    total++; if (bus0.I_RDY !== 1'b1) $display("FAIL bp_release_rdy got %b exp 1", bus0.I_RDY); else passed++;
    tick0();
    total++; if (bus0.O_VLD !== mv || bus0.O[8:6] !== 3'd6 || bus0.O_VLD[2] !== 1'b1)
      $display("FAIL bp_refill got %h/%0d exp %h/6", bus0.O_VLD, bus0.O[8:6], mv); else passed++;
  endtask

  task automatic test_independence();
    drive0(1'b1, 3'd3, 3'd7, 8'hF7);
    tick0();
    for (int n = 0; n < 4; n++) begin
      drive0(1'b1, 3'd5, 3'($urandom_range(7)), 8'hF7);
      total++; if (bus0.I_RDY !== 1'b1) $display("FAIL indep_rdy n%0d got %b exp 1", n, bus0.I_RDY); else passed++;
      tick0();
      total++; if (bus0.O !== m_o() || bus0.O_VLD !== mv)
        $display("FAIL indep_state n%0d got %h/%h exp %h/%h", n, bus0.O, bus0.O_VLD, m_o(), mv); else passed++;
      total++; if (bus0.O_VLD[3] !== 1'b1 || bus0.O[11:9] !== 3'd7 || bus0.O_VLD[5] !== 1'b1)
        $display("FAIL indep_ch3 n%0d got %b/%0d exp 1/7", n, bus0.O_VLD[3], bus0.O[11:9]); else passed++;
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      drive0(1'($urandom_range(1)), 3'($urandom_range(7)), 3'($urandom_range(7)), 8'($urandom));
      total++; if (bus0.I_RDY !== m_rdy(bus0.S, bus0.O_RDY, 1'b0))
        $display("FAIL rand_rdy n%0d got %b exp %b", n, bus0.I_RDY, m_rdy(bus0.S, bus0.O_RDY, 1'b0)); else passed++;
      tick0();
      total++; if (bus0.O !== m_o() || bus0.O_VLD !== mv)
        $display("FAIL rand_state n%0d got %h/%h exp %h/%h", n, bus0.O, bus0.O_VLD, m_o(), mv); else passed++;
      total++; if (bus0.ERR !== 1'b0 || bus0.DROP_CNT !== 8'h0)
        $display("FAIL rand_nodrop n%0d got %b/%h exp 0/0", n, bus0.ERR, bus0.DROP_CNT); else passed++;
    end
  endtask

  task automatic test_drop();
    logic [1:0] exp_cnt;
    exp_cnt = 2'd0;
    bus1.E = 1'b1; bus1.S = 3'd1; bus1.I = 3'd2; bus1.O_RDY = 6'b111101;
    @(posedge clk); #1;
    total++; if (bus1.O_VLD !== 6'b000010 || bus1.ERR !== 1'b0)
      $display("FAIL drop_setup got %b/%b exp 000010/0", bus1.O_VLD, bus1.ERR); else passed++;
    for (int n = 0; n < 5; n++) begin
      bus1.S = (n == 0) ? 3'd6 : (n == 1) ? 3'd7 : 3'($urandom_range(7, 6));
      bus1.I = 3'd3;
      #1;
      total++; if (bus1.I_RDY !== 1'b1) $display("FAIL drop_rdy n%0d got %b exp 1", n, bus1.I_RDY); else passed++;
      @(posedge clk); #1;
      if (exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
      total++; if (bus1.ERR !== 1'b1 || bus1.DROP_CNT !== exp_cnt)
        $display("FAIL drop_count n%0d got %b/%0d exp 1/%0d", n, bus1.ERR, bus1.DROP_CNT, exp_cnt); else passed++;
      total++; if (bus1.O_VLD !== 6'b000010 || bus1.O[5:3] !== 3'd2)
        $display("FAIL drop_nochange n%0d got %b/%0d exp 000010/2", n, bus1.O_VLD, bus1.O[5:3]); else passed++;
    end
    bus1.E = 1'b0;
    #1;
    total++; if (bus1.I_RDY !== 1'b1) $display("FAIL drop_idle_rdy got %b exp 1", bus1.I_RDY); else passed++;
    @(posedge clk); #1;
    total++; if (bus1.ERR !== 1'b0 || bus1.DROP_CNT !== 2'd3)
      $display("FAIL drop_idle got %b/%0d exp 0/3", bus1.ERR, bus1.DROP_CNT); else passed++;
  endtask

  task automatic test_reset_mid();
    drive0(1'b1, 3'd0, 3'd5, 8'hEE);
    tick0();
    drive0(1'b1, 3'd4, 3'd6, 8'hEE);
    tick0();
    total++; if (bus0.O_VLD !== 8'h11) $display("FAIL rmid_setup got %h exp 11", bus0.O_VLD); else passed++;
    drive0(1'b0, 3'd0, 3'd0, 8'hEE);
    rst_n = 1'b0;
    #1;
    total++; if (bus0.O_VLD !== 8'h0 || bus0.O !== 24'h0)
      $display("FAIL rmid_async got %h/%h exp 0/0", bus0.O_VLD, bus0.O); else passed++;
    total++; if (bus1.DROP_CNT !== 2'd0 || bus1.O_VLD !== 6'h0)
      $display("FAIL rmid_dut1 got %0d/%b exp 0/0", bus1.DROP_CNT, bus1.O_VLD); else passed++;
    #1;
    rst_n = 1'b1;
    m_reset();
    drive0(1'b1, 3'd4, 3'd3, 8'hFF);
    total++; if (bus0.I_RDY !== 1'b1) $display("FAIL rmid_rdy got %b exp 1", bus0.I_RDY); else passed++;
    tick0();
    total++; if (bus0.O_VLD !== 8'h10 || bus0.O[14:12] !== 3'd3 || bus0.O !== m_o())
      $display("FAIL rmid_accept got %h/%h exp 10/%h", bus0.O_VLD, bus0.O, m_o()); else passed++;
  endtask

`ifdef DEMUX_STREAM_BROADCAST_EN
  task automatic test_broadcast();
    drive0(1'b0, 3'd0, 3'd0, 8'hFF);
    tick0();
    drive0(1'b1, 3'($urandom_range(7)), 3'd4, 8'hFF);
    bus0.B = 1'b1;
    #1;
    total++; if (bus0.I_RDY !== 1'b1) $display("FAIL bc_rdy got %b exp 1", bus0.I_RDY); else passed++;
    tick0();
    total++; if (bus0.O_VLD !== 8'hFF || bus0.O !== 24'o44444444)
      $display("FAIL bc_write got %h/%h exp ff/%h", bus0.O_VLD, bus0.O, 24'o44444444); else passed++;
    drive0(1'b1, 3'd0, 3'd1, 8'hBF);
    bus0.B = 1'b1;
    #1;
    total++; if (bus0.I_RDY !== 1'b0) $display("FAIL bc_block_rdy got %b exp 0", bus0.I_RDY); else passed++;
    tick0();
    total++; if (bus0.O !== 24'o44444444 || bus0.O_VLD !== 8'h40 || bus0.O_VLD !== mv)
      $display("FAIL bc_block got %h/%h exp %h/40", bus0.O, bus0.O_VLD, 24'o44444444); else passed++;
    bus0.B = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_route();
    test_backpressure();
    test_independence();
    test_random();
    test_drop();
    test_reset_mid();
`ifdef DEMUX_STREAM_BROADCAST_EN
    test_broadcast();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
